// File: rtl/cpu_io_port.sv
// ============================================================================
// Module      : cpu_io_port
// Description : I/O endpoint for the 4-bit processor. An output FIFO carries
//               OUT A nibbles to a host; an input FIFO carries host nibbles
//               to IN A. Both FIFOs are first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_io_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     osc_clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         cpu_data_out,
    input  logic                     cpu_out_strobe,
    input  logic                     cpu_in_strobe,
    output logic [WIDTH-1:0]         cpu_data_in,
    output logic                     cpu_in_avail,
    output logic                     cpu_out_space,
    output logic [WIDTH-1:0]         host_rx_data,
    output logic                     host_rx_valid,
    input  logic                     host_rx_ready,
    input  logic [WIDTH-1:0]         host_tx_data,
    input  logic                     host_tx_valid,
    output logic                     host_tx_ready,
    input  logic                     clear_flags,
    output logic                     ovf_flag,
    output logic                     udf_flag,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic [$clog2(DEPTH):0]   in_count
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam int              c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // ---------------- output FIFO (processor -> host) ----------------
    logic [WIDTH-1:0]   r_out_mem [DEPTH];
    logic [c_PTR_W-1:0] r_out_wr;
    logic [c_PTR_W-1:0] r_out_rd;
    logic [c_CNT_W-1:0] r_out_cnt;
    logic               w_out_empty;
    logic               w_out_full;
    logic               w_out_push;
    logic               w_out_pop;

    // ---------------- input FIFO (host -> processor) ----------------
    logic [WIDTH-1:0]   r_in_mem [DEPTH];
    logic [c_PTR_W-1:0] r_in_wr;
    logic [c_PTR_W-1:0] r_in_rd;
    logic [c_CNT_W-1:0] r_in_cnt;
    logic               w_in_empty;
    logic               w_in_full;
    logic               w_in_push;
    logic               w_in_pop;

    logic               r_ovf;
    logic               r_udf;
    logic               w_ovf_evt;
    logic               w_udf_evt;

    // Full/empty come only from registered counts, so no ready/valid
    // combinational loops exist toward the host.
    assign w_out_empty = (r_out_cnt == '0);
    assign w_out_full  = (r_out_cnt == c_FULL);
    assign w_out_push  = cpu_out_strobe && !w_out_full;
    assign w_out_pop   = !w_out_empty && host_rx_ready;
    assign w_ovf_evt   = cpu_out_strobe && w_out_full;

    assign w_in_empty  = (r_in_cnt == '0);
    assign w_in_full   = (r_in_cnt == c_FULL);
    assign w_in_push   = host_tx_valid && !w_in_full;
    assign w_in_pop    = cpu_in_strobe && !w_in_empty;
    assign w_udf_evt   = cpu_in_strobe && w_in_empty;

    // Storage is deliberately not reset; head outputs are gated by empty.
    always_ff @(posedge osc_clock) begin
        if (w_out_push) r_out_mem[r_out_wr] <= cpu_data_out;
        if (w_in_push)  r_in_mem[r_in_wr]   <= host_tx_data;
    end

    always_ff @(posedge osc_clock or posedge reset) begin
        if (reset) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
            r_in_wr   <= '0;
            r_in_rd   <= '0;
            r_in_cnt  <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
            if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase

            if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
            if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + 1'b1;
                2'b01:   r_in_cnt <= r_in_cnt - 1'b1;
                default: r_in_cnt <= r_in_cnt;
            endcase

            // A set event outranks a simultaneous clear.
            if (w_ovf_evt)        r_ovf <= 1'b1;
            else if (clear_flags) r_ovf <= 1'b0;
            if (w_udf_evt)        r_udf <= 1'b1;
            else if (clear_flags) r_udf <= 1'b0;
        end
    end

    assign host_rx_data  = w_out_empty ? '0 : r_out_mem[r_out_rd];
    assign host_rx_valid = !w_out_empty;
    assign cpu_out_space = !w_out_full;
    assign out_count     = r_out_cnt;

    assign cpu_data_in   = w_in_empty ? '0 : r_in_mem[r_in_rd];
    assign cpu_in_avail  = !w_in_empty;
    assign host_tx_ready = !w_in_full;
    assign in_count      = r_in_cnt;

    assign ovf_flag      = r_ovf;
    assign udf_flag      = r_udf;

endmodule

`default_nettype wire
